skew_mes_ctl_mc: RTL and testbench

Multi-channel, parametrised successor to the single-channel skew measurement controller. Per enabled channel it steps the strobe delay code, requests strobes from stb_gen, and majority-votes the latched comparator output. It reports the smallest delay code at which the comparator reads 1, i.e. the channel skew in delay-step units. Search mode is selectable per run: linear sweep or binary search.

---
 rtl/skew_mes_ctl_mc.sv | 254 +++++++++++++++++++++++++
 tb/tb_skew_mes_ctl_mc.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/skew_mes_ctl_mc.sv
// Multi-channel skew measurement controller: per enabled channel, search the smallest
// strobe delay code at which the majority-voted comparator output reads 1.
module skew_mes_ctl_mc #(
  parameter int CH_N      = 4,
  parameter int DLY_W     = 10,
  parameter int SMPL_W    = 4,
  parameter int SETTLE    = 2,
  parameter int TIMEOUT_W = 16,
  localparam int CH_W     = (CH_N > 1) ? $clog2(CH_N) : 1
) (
  input  logic                  clk_i,
  input  logic                  arst_i,
  input  logic                  run_i,
  input  logic                  mode_i,
  input  logic [CH_N-1:0]       ch_mask_i,
  input  logic [SMPL_W-1:0]     smpl_n_i,
  input  logic [CH_N-1:0]       cmp_out_i,
  input  logic                  stb_valid_i,
  output logic                  stb_req_o,
  output logic [DLY_W-1:0]      delay_code_o,
  output logic [CH_W-1:0]       ch_sel_o,
  output logic [CH_N*DLY_W-1:0] res_code_o,
  output logic [CH_N-1:0]       res_valid_o,
  output logic [CH_N-1:0]       ch_err_o,
  output logic                  busy_o,
  output logic                  rdy_o,
  output logic                  err_o
);

  localparam int ST_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [ST_W-1:0] SETTLE_LAST = ST_W'((SETTLE > 0) ? SETTLE - 1 : 0);
  localparam logic [DLY_W-1:0] MAX_CODE = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_NEXT_CH, S_SET_CODE, S_REQ, S_WAIT_SMPL, S_EVAL, S_DONE, S_ERR
  } state_t;

  // Handshake: stb_req_o is high for every cycle spent in S_REQ; a one-cycle
  // stb_valid_i seen there completes the strobe and req drops on the next cycle.
  state_t                state_q, state_d;
  logic                  run_q;
  logic                  mode_q, mode_d;
  logic [CH_N-1:0]       mask_q, mask_d, done_q, done_d;
  logic [SMPL_W-1:0]     smpl_q, smpl_d;
  logic [CH_W-1:0]       ch_q, ch_d;
  logic [DLY_W-1:0]      code_q, code_d;
  logic [DLY_W:0]        lo_q, lo_d, hi_q, hi_d;
  logic [ST_W-1:0]       cnt_q, cnt_d;
  logic [TIMEOUT_W-1:0]  tmo_q, tmo_d;
  logic [SMPL_W:0]       scnt_q, scnt_d, ones_q, ones_d;
  logic [CH_N*DLY_W-1:0] res_q, res_d;
  logic [CH_N-1:0]       val_q, val_d, cerr_q, cerr_d;

  logic [CH_N-1:0] pend;
  logic [SMPL_W:0] smpl_eff;
  logic            decision, start, busy;
  logic            pick_found;
  logic [CH_W-1:0] pick_idx;
  logic [DLY_W:0]  nlo, nhi, mid_sum;

  assign pend     = mask_q & ~done_q;
  assign smpl_eff = (smpl_q == '0) ? (SMPL_W+1)'(1) : {1'b0, smpl_q};
  assign decision = {ones_q, 1'b0} > {1'b0, smpl_eff};
  assign start    = run_i & ~run_q;
  assign busy     = (state_q == S_NEXT_CH) || (state_q == S_SET_CODE) || (state_q == S_REQ) ||
                    (state_q == S_WAIT_SMPL) || (state_q == S_EVAL);

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int i = CH_N - 1; i >= 0; i--) begin
      if (pend[i]) begin
        pick_found = 1'b1;
        pick_idx   = CH_W'(i);
      end
    end
  end

  // Binary search bounds after the current probe; the max-code probe leaves hi at max.
  always_comb begin
    nlo = lo_q;
    nhi = hi_q;
    if (decision) nhi = {1'b0, code_q};
    else          nlo = {1'b0, code_q} + (DLY_W+1)'(1);
    mid_sum = (nlo + nhi) >> 1;
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    mask_d  = mask_q;
    done_d  = done_q;
    smpl_d  = smpl_q;
    ch_d    = ch_q;
    code_d  = code_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    scnt_d  = scnt_q;
    ones_d  = ones_q;
    res_d   = res_q;
    val_d   = val_q;
    cerr_d  = cerr_q;
    if (busy && !run_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            mode_d  = mode_i;
            mask_d  = ch_mask_i;
            smpl_d  = smpl_n_i;
            done_d  = '0;
            val_d   = '0;
            cerr_d  = '0;
            state_d = S_NEXT_CH;
          end
        end
        S_NEXT_CH: begin
          if (pick_found) begin
            ch_d    = pick_idx;
            code_d  = mode_q ? MAX_CODE : '0;
            lo_d    = '0;
            hi_d    = {1'b0, MAX_CODE};
            scnt_d  = '0;
            ones_d  = '0;
            cnt_d   = '0;
            state_d = S_SET_CODE;
          end else begin
            state_d = S_DONE;
          end
        end
        S_SET_CODE: begin
          if (cnt_q == SETTLE_LAST) begin
            tmo_d   = '0;
            state_d = S_REQ;
          end else begin
            cnt_d = cnt_q + ST_W'(1);
          end
        end
        S_REQ: begin
          if (stb_valid_i) begin
            cnt_d   = '0;
            state_d = S_WAIT_SMPL;
          end else if (tmo_q == '1) begin
            state_d = S_ERR;
          end else begin
            tmo_d = tmo_q + TIMEOUT_W'(1);
          end
        end
        S_WAIT_SMPL: begin
          if (cnt_q == SETTLE_LAST) begin
            ones_d = ones_q + {{SMPL_W{1'b0}}, cmp_out_i[ch_q]};
            scnt_d = scnt_q + (SMPL_W+1)'(1);
            if ((scnt_q + (SMPL_W+1)'(1)) >= smpl_eff) begin
              state_d = S_EVAL;
            end else begin
              tmo_d   = '0;
              state_d = S_REQ;
            end
          end else begin
            cnt_d = cnt_q + ST_W'(1);
          end
        end
        S_EVAL: begin
          scnt_d = '0;
          ones_d = '0;
          cnt_d  = '0;
          // Max code is only probed first in binary mode or last in linear mode.
          if (!decision && code_q == MAX_CODE) begin
            cerr_d[ch_q] = 1'b1;
            done_d[ch_q] = 1'b1;
            state_d      = S_NEXT_CH;
          end else if (!mode_q) begin
            if (decision) begin
              res_d[ch_q*DLY_W +: DLY_W] = code_q;
              val_d[ch_q]  = 1'b1;
              done_d[ch_q] = 1'b1;
              state_d      = S_NEXT_CH;
            end else begin
              code_d  = code_q + DLY_W'(1);
              state_d = S_SET_CODE;
            end
          end else begin
            lo_d = nlo;
            hi_d = nhi;
            if (nlo < nhi) begin
              code_d  = mid_sum[DLY_W-1:0];
              state_d = S_SET_CODE;
            end else begin
              res_d[ch_q*DLY_W +: DLY_W] = nlo[DLY_W-1:0];
              val_d[ch_q]  = 1'b1;
              done_d[ch_q] = 1'b1;
              state_d      = S_NEXT_CH;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q <= S_IDLE;
      run_q   <= 1'b0;
      mode_q  <= 1'b0;
      mask_q  <= '0;
      done_q  <= '0;
      smpl_q  <= '0;
      ch_q    <= '0;
      code_q  <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      scnt_q  <= '0;
      ones_q  <= '0;
      res_q   <= '0;
      val_q   <= '0;
      cerr_q  <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_i;
      mode_q  <= mode_d;
      mask_q  <= mask_d;
      done_q  <= done_d;
      smpl_q  <= smpl_d;
      ch_q    <= ch_d;
      code_q  <= code_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      scnt_q  <= scnt_d;
      ones_q  <= ones_d;
      res_q   <= res_d;
      val_q   <= val_d;
      cerr_q  <= cerr_d;
    end
  end

  assign stb_req_o    = (state_q == S_REQ);
  assign delay_code_o = code_q;
  assign ch_sel_o     = ch_q;
  assign res_code_o   = res_q;
  assign res_valid_o  = val_q;
  assign ch_err_o     = cerr_q;
  assign busy_o       = busy;
  assign rdy_o        = (state_q == S_DONE);
  assign err_o        = (state_q == S_ERR);

endmodule

// File: tb/tb_skew_mes_ctl_mc.sv
// Directed bench for skew_mes_ctl_mc: stb_gen stub, threshold comparator model with
// optional sample inversion, and hand-computed per-channel results.
module tb_skew_mes_ctl_mc;

  localparam int CH_N      = 4;
  localparam int DLY_W     = 10;
  localparam int SMPL_W    = 4;
  localparam int SETTLE    = 2;
  localparam int TIMEOUT_W = 8;
  localparam int CH_W      = 2;

  logic                  clk_i = 1'b0;
  logic                  arst_i;
  logic                  run_i;
  logic                  mode_i;
  logic [CH_N-1:0]       ch_mask_i;
  logic [SMPL_W-1:0]     smpl_n_i;
  logic [CH_N-1:0]       cmp_out_i;
  logic                  stb_valid_i;
  logic                  stb_req_o;
  logic [DLY_W-1:0]      delay_code_o;
  logic [CH_W-1:0]       ch_sel_o;
  logic [CH_N*DLY_W-1:0] res_code_o;
  logic [CH_N-1:0]       res_valid_o;
  logic [CH_N-1:0]       ch_err_o;
  logic                  busy_o;
  logic                  rdy_o;
  logic                  err_o;

  // clock / reset
  always #5 clk_i = ~clk_i;

  skew_mes_ctl_mc #(
    .CH_N(CH_N), .DLY_W(DLY_W), .SMPL_W(SMPL_W), .SETTLE(SETTLE), .TIMEOUT_W(TIMEOUT_W)
  ) dut (
    .clk_i(clk_i), .arst_i(arst_i), .run_i(run_i), .mode_i(mode_i),
    .ch_mask_i(ch_mask_i), .smpl_n_i(smpl_n_i), .cmp_out_i(cmp_out_i),
    .stb_valid_i(stb_valid_i), .stb_req_o(stb_req_o), .delay_code_o(delay_code_o),
    .ch_sel_o(ch_sel_o), .res_code_o(res_code_o), .res_valid_o(res_valid_o),
    .ch_err_o(ch_err_o), .busy_o(busy_o), .rdy_o(rdy_o), .err_o(err_o)
  );

  int checks = 0;
  int errors = 0;
  logic [DLY_W-1:0] exp_q[$];

  // comparator and stb_gen models
  int skew [CH_N];
  bit stub_off = 1'b0;
  bit inv_en   = 1'b0;
  int inv_per  = 5;
  int stb_idx  = 0;
  int req_cnt  = 0;
  logic req_prev = 1'b0;
  int ch_log[$];

  always @(negedge clk_i) begin
    logic [CH_N-1:0] nc;
    bit inv;
    if (arst_i) begin
      stb_valid_i = 1'b0;
      req_cnt     = 0;
      req_prev    = 1'b0;
    end else begin
      stb_valid_i = 1'b0;
      if (stb_req_o && !req_prev) ch_log.push_back(int'(ch_sel_o));
      req_prev = stb_req_o;
      if (stb_req_o && !stub_off) begin
        req_cnt++;
        if (req_cnt == 3) begin
          req_cnt = 0;
          inv = inv_en && ((stb_idx % inv_per) < 2);
          for (int c = 0; c < CH_N; c++) nc[c] = (int'(delay_code_o) >= skew[c]) ^ inv;
          cmp_out_i   = nc;
          stb_valid_i = 1'b1;
          stb_idx++;
        end
      end else begin
        req_cnt = 0;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, act, exp);
    end
  endtask

  task automatic check_codes();
    logic [DLY_W-1:0] e;
    for (int c = 0; c < CH_N; c++) begin
      e = exp_q.pop_front();
      check($sformatf("res_code[%0d]", c), 64'(res_code_o[c*DLY_W +: DLY_W]), 64'(e));
    end
  endtask

  task automatic push_codes(input int c0, input int c1, input int c2, input int c3);
    exp_q.push_back(DLY_W'(c0));
    exp_q.push_back(DLY_W'(c1));
    exp_q.push_back(DLY_W'(c2));
    exp_q.push_back(DLY_W'(c3));
  endtask

  task automatic set_skew(input int s0, input int s1, input int s2, input int s3);
    skew[0] = s0; skew[1] = s1; skew[2] = s2; skew[3] = s3;
  endtask

  task automatic pulse_reset();
    @(negedge clk_i);
    arst_i = 1'b1;
    run_i  = 1'b0;
    @(negedge clk_i);
    arst_i = 1'b0;
  endtask

  // Starts a run and waits for rdy_o or err_o within a cycle budget.
  task automatic do_run(input logic m, input logic [CH_N-1:0] mask, input logic [SMPL_W-1:0] sn,
                        input int budget);
    int cyc;
    @(negedge clk_i);
    mode_i = m; ch_mask_i = mask; smpl_n_i = sn; run_i = 1'b1;
    @(negedge clk_i);
    cyc = 0;
    while (!(rdy_o || err_o) && cyc < budget) begin
      @(negedge clk_i);
      cyc++;
    end
    check("run_completes", 64'(rdy_o | err_o), 64'd1);
    run_i = 1'b0;
  endtask

  task automatic check_done(input logic [CH_N-1:0] val, input logic [CH_N-1:0] cerr);
    check("rdy_o", 64'(rdy_o), 64'd1);
    check("err_o", 64'(err_o), 64'd0);
    check("busy_o", 64'(busy_o), 64'd0);
    check("res_valid", 64'(res_valid_o), 64'(val));
    check("ch_err", 64'(ch_err_o), 64'(cerr));
  endtask

  initial begin
    int base, n, last, cyc;
    logic [15:0] seq;
    arst_i = 1'b1; run_i = 1'b0; mode_i = 1'b0; ch_mask_i = '0; smpl_n_i = '0;
    cmp_out_i = '0; stb_valid_i = 1'b0;
    set_skew(0, 137, 512, 1023);
    repeat (3) @(negedge clk_i);
    check("reset_outputs", 64'({stb_req_o, busy_o, rdy_o, err_o, res_valid_o, ch_err_o}), 64'd0);
    check("reset_code_sel", 64'({delay_code_o, ch_sel_o}), 64'd0);
    check("reset_res_code", 64'(res_code_o), 64'd0);
    arst_i = 1'b0;

    // linear sweep, all channels, one sample per code
    do_run(1'b0, 4'hF, 4'd1, 30000);
    check_done(4'hF, 4'h0);
    push_codes(0, 137, 512, 1023);
    check_codes();

    // binary search: same results, 11 probes per channel, channels in order
    base = ch_log.size();
    do_run(1'b1, 4'hF, 4'd1, 5000);
    check_done(4'hF, 4'h0);
    push_codes(0, 137, 512, 1023);
    check_codes();
    seq = '0; last = -1;
    for (int c = 0; c < CH_N; c++) begin
      n = 0;
      for (int i = base; i < ch_log.size(); i++) if (ch_log[i] == c) n++;
      check($sformatf("bin_probes[%0d]", c), 64'(n), 64'd11);
    end
    for (int i = base; i < ch_log.size(); i++) begin
      if (ch_log[i] != last) begin
        seq  = {seq[11:0], 4'(ch_log[i] + 1)};
        last = ch_log[i];
      end
    end
    check("ch_order", 64'(seq), 64'h1234);

    // empty mask: done two cycles after the run edge, results cleared
    @(negedge clk_i);
    ch_mask_i = '0; run_i = 1'b1;
    @(negedge clk_i);
    check("empty_busy", 64'({busy_o, rdy_o}), 64'b10);
    check("empty_valid_cleared", 64'(res_valid_o), 64'd0);
    @(negedge clk_i);
    check("empty_done", 64'({busy_o, rdy_o}), 64'b01);
    run_i = 1'b0;

    // mask 0101, channel 2 never reads 1
    pulse_reset();
    set_skew(42, 5, 2000, 5);
    do_run(1'b0, 4'h5, 4'd1, 20000);
    check_done(4'h1, 4'h4);
    push_codes(42, 0, 0, 0);
    check_codes();

    // five samples per code, two of every five inverted
    set_skew(300, 0, 0, 0);
    inv_en = 1'b1; inv_per = 5;
    do_run(1'b0, 4'h1, 4'd5, 20000);
    check_done(4'h1, 4'h0);
    check("maj5_linear", 64'(res_code_o[DLY_W-1:0]), 64'd300);
    do_run(1'b1, 4'h1, 4'd5, 5000);
    check_done(4'h1, 4'h0);
    check("maj5_binary", 64'(res_code_o[DLY_W-1:0]), 64'd300);

    // four samples with two ones is a tie and reads as 0 at max code
    set_skew(0, 0, 0, 0);
    inv_per = 4;
    do_run(1'b1, 4'h1, 4'd4, 2000);
    check_done(4'h0, 4'h1);
    inv_en = 1'b0;

    // strobe timeout
    stub_off = 1'b1;
    @(negedge clk_i);
    mode_i = 1'b0; ch_mask_i = 4'h1; smpl_n_i = 4'd1; run_i = 1'b1;
    cyc = 0; n = 0;
    while (!err_o && cyc < 1000) begin
      @(negedge clk_i);
      cyc++;
      if (stb_req_o) n++;
    end
    check("timeout_req_cycles", 64'(n), 64'd256);
    check("timeout_flags", 64'({err_o, rdy_o, busy_o, stb_req_o}), 64'b1000);
    run_i = 1'b0;
    stub_off = 1'b0;

    // abort while measuring channel 2
    set_skew(5, 10, 600, 700);
    @(negedge clk_i);
    mode_i = 1'b0; ch_mask_i = 4'hF; smpl_n_i = 4'd1; run_i = 1'b1;
    cyc = 0;
    while (!(busy_o && ch_sel_o == 2'd2) && cyc < 5000) begin
      @(negedge clk_i);
      cyc++;
    end
    check("abort_reached_ch2", 64'(ch_sel_o), 64'd2);
    repeat (10) @(negedge clk_i);
    run_i = 1'b0;
    @(negedge clk_i);
    check("abort_flags", 64'({busy_o, stb_req_o, rdy_o, err_o}), 64'd0);
    check("abort_valid", 64'(res_valid_o), 64'b0011);
    check("abort_code0", 64'(res_code_o[0 +: DLY_W]), 64'd5);
    check("abort_code1", 64'(res_code_o[DLY_W +: DLY_W]), 64'd10);

    // asynchronous reset mid-run, then a clean run
    @(negedge clk_i);
    run_i = 1'b1;
    repeat (50) @(negedge clk_i);
    arst_i = 1'b1;
    #1;
    check("arst_outputs", 64'({stb_req_o, busy_o, rdy_o, err_o, res_valid_o, ch_err_o, ch_sel_o}),
          64'd0);
    check("arst_res_code", 64'({res_code_o, delay_code_o}), 64'd0);
    @(negedge clk_i);
    arst_i = 1'b0; run_i = 1'b0;
    set_skew(3, 7, 0, 20);
    do_run(1'b0, 4'hF, 4'd1, 5000);
    check_done(4'hF, 4'h0);
    push_codes(3, 7, 0, 20);
    check_codes();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule
